// File: rtl/jt12_kon_sched.sv
// Key-on command scheduler: queues CPU writes to register 0x28 and
// applies each one for a full 24-slot frame aligned to slot 0.
//
// Ports:
//   clk, rst (sync, active-high), clk_en (slot advance)
//   wr_en/wr_data : CPU key-on write ([7:4] op mask, [2:0] channel)
//   zero          : slot-0 marker, qualified by clk_en
//   keyon_op/keyon_ch/up_keyon : command presented to key-on shifter
//   level         : queued command count
//   ovf           : sticky drop flag (full FIFO or invalid channel)
module jt12_kon_sched #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       zero,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic [4:0] level,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);
  localparam logic [4:0] LAST_SLOT = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ZERO,
    APPLY
  } state_t;

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [4:0]    cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    ch_q, ch_d;
  logic          up_q, up_d;
  logic          ovf_q, ovf_d;

  logic wr_valid;
  logic full;
  logic pop;
  logic push;
  logic unused_wr_bit;

  assign unused_wr_bit = wr_data[3];

  always_comb begin
    // Channels 3 and 7 do not exist on this chip.
    wr_valid = wr_en && (wr_data[1:0] != 2'b11);
    full     = (level_q == DEPTH_L);
    pop      = clk_en && (state_q == APPLY) && (cnt_q == LAST_SLOT);
    // A pop on the same edge frees the slot a full FIFO would lack.
    push     = wr_valid && (!full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ch_d     = ch_q;
    up_d     = up_q;
    ovf_d    = ovf_q | (wr_en & ~wr_valid) | (wr_valid & ~push);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + {4'd0, push} - {4'd0, pop};

    if (clk_en) begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (level_q != 5'd0) state_d = WAIT_ZERO;
        end
        (state_q == WAIT_ZERO): begin
          if (zero) begin
            state_d      = APPLY;
            {op_d, ch_d} = mem_q[rd_ptr_q];
            cnt_d        = 5'd0;
            up_d         = 1'b1;
          end
        end
        (state_q == APPLY): begin
          if (cnt_q == LAST_SLOT) begin
            up_d    = 1'b0;
            cnt_d   = 5'd0;
            state_d = (level_d != 5'd0) ? WAIT_ZERO : IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      cnt_q    <= 5'd0;
      state_q  <= IDLE;
      op_q     <= 4'd0;
      ch_q     <= 3'd0;
      up_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      op_q     <= op_d;
      ch_q     <= ch_d;
      up_q     <= up_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {wr_data[7:4], wr_data[2:0]};
    end
  end

  assign keyon_op = op_q;
  assign keyon_ch = ch_q;
  assign up_keyon = up_q;
  assign level    = level_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_jt12_kon_sched.sv
// Directed bench for jt12_kon_sched: single command, overflow,
// invalid channels, sparse clk_en, mid-frame reset, full push+pop.
module tb_jt12_kon_sched;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       zero;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic [4:0] level;
  logic       ovf;

  int   n_chk;
  int   n_err;
  int   slot;
  int   phase;
  int   en_period;
  logic last_zero;

  jt12_kon_sched #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .zero     (zero),
    .keyon_op (keyon_op),
    .keyon_ch (keyon_ch),
    .up_keyon (up_keyon),
    .level    (level),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // One clock; zero marks slot 0 of the bench's own slot counter.
  task automatic tick(input logic en);
    clk_en    = en;
    zero      = en && (slot == 0);
    last_zero = zero;
    @(posedge clk);
    #1;
    if (en) slot = (slot == 23) ? 0 : slot + 1;
    wr_en = 1'b0;
  endtask

  task automatic cyc();
    logic en;
    en    = (phase == 0);
    phase = (phase + 1 == en_period) ? 0 : phase + 1;
    tick(en);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_rise(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (up_keyon) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Clocks with up_keyon high, counting the rise observation.
  task automatic measure(output int n);
    n = 1;
    for (int i = 0; i < 3000 && up_keyon; i++) begin
      cyc();
      if (up_keyon) n++;
    end
  endtask

  task automatic no_rise(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (up_keyon) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic       ok;
    int         n;
    logic [3:0] mk [4];
    logic [3:0] fop [4];
    logic [2:0] fch [4];

    n_chk     = 0;
    n_err     = 0;
    slot      = 0;
    phase     = 0;
    en_period = 1;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    clk_en    = 1'b0;
    zero      = 1'b0;
    last_zero = 1'b0;

    repeat (3) cyc();
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_up", up_keyon, 0);
    chk("rst_op", keyon_op, 0);
    chk("rst_ch", keyon_ch, 0);
    rst = 1'b0;

    // Single command 0xF1
    wr(8'hF1);
    chk("a_level1", level, 1);
    wait_rise(ok);
    chk("a_rise", ok, 1);
    chk("a_zero", last_zero, 1);
    chk("a_op", keyon_op, 4'hF);
    chk("a_ch", keyon_ch, 3'd1);
    chk("a_lvl_apply", level, 1);
    measure(n);
    chk("a_len", n, 24);
    chk("a_level0", level, 0);
    chk("a_op_hold", keyon_op, 4'hF);
    chk("a_ch_hold", keyon_ch, 3'd1);

    // Invalid channels
    wr(8'hF3);
    wr(8'hF7);
    chk("c_level", level, 0);
    chk("c_ovf", ovf, 1);
    no_rise("c_no_up", 60);
    chk("c_ovf_sticky", ovf, 1);

    // Overflow with DEPTH=4
    do_reset();
    chk("b_ovf_rst", ovf, 0);
    wr(8'h10);
    wr(8'h20);
    wr(8'h40);
    wr(8'h80);
    wr(8'h12);
    chk("b_level4", level, 4);
    chk("b_ovf", ovf, 1);
    mk = '{4'h1, 4'h2, 4'h4, 4'h8};
    for (int k = 0; k < 4; k++) begin
      wait_rise(ok);
      chk($sformatf("b_rise%0d", k), ok, 1);
      chk($sformatf("b_op%0d", k), keyon_op, mk[k]);
      chk($sformatf("b_ch%0d", k), keyon_ch, 0);
      chk($sformatf("b_lvl%0d", k), level, 5'(4 - k));
      measure(n);
      chk($sformatf("b_len%0d", k), n, 24);
    end
    chk("b_level0", level, 0);
    no_rise("b_no_fifth", 80);

    // Reset mid-APPLY, with a write in the reset cycle
    do_reset();
    wr(8'h91);
    wr(8'h26);
    wait_rise(ok);
    chk("d_rise", ok, 1);
    repeat (10) cyc();
    chk("d_up_mid", up_keyon, 1);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h31;
    cyc();
    rst = 1'b0;
    chk("d_up", up_keyon, 0);
    chk("d_level", level, 0);
    chk("d_ovf", ovf, 0);
    chk("d_op", keyon_op, 0);
    chk("d_ch", keyon_ch, 0);
    no_rise("d_no_apply", 100);
    chk("d_level_after", level, 0);

    // Full FIFO, write on the popping edge
    do_reset();
    wr(8'h11);
    wr(8'h21);
    wr(8'h41);
    wr(8'h81);
    chk("f_level4", level, 4);
    chk("f_ovf0", ovf, 0);
    wait_rise(ok);
    chk("f_rise", ok, 1);
    chk("f_op0", keyon_op, 4'h1);
    repeat (23) cyc();
    chk("f_pre", up_keyon, 1);
    wr(8'h22);
    chk("f_up_fall", up_keyon, 0);
    chk("f_level", level, 4);
    chk("f_ovf", ovf, 0);
    fop = '{4'h2, 4'h4, 4'h8, 4'h2};
    fch = '{3'd1, 3'd1, 3'd1, 3'd2};
    for (int k = 0; k < 4; k++) begin
      wait_rise(ok);
      chk($sformatf("f_rise%0d", k), ok, 1);
      chk($sformatf("f_op%0d", k), keyon_op, fop[k]);
      chk($sformatf("f_ch%0d", k), keyon_ch, fch[k]);
      measure(n);
    end
    chk("f_level0", level, 0);

    // Sparse clk_en, one in six clocks
    en_period = 6;
    phase     = 0;
    do_reset();
    wr(8'h55);
    wait_rise(ok);
    chk("e_rise", ok, 1);
    chk("e_zero", last_zero, 1);
    chk("e_op", keyon_op, 4'h5);
    chk("e_ch", keyon_ch, 3'd5);
    measure(n);
    chk("e_len", n, 144);
    chk("e_level0", level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jt12_kon_sched.md
JT12_KON_SCHED -- requirements
Module: jt12_kon_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning key-on command FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  master clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clk_en  input  1  slot-advance enable; one slot per clk_en-high cycle.
REQ-005 SHALL have port wr_en  input  1  single-clk pulse: CPU write to key-on register 0x28.
REQ-006 SHALL have port wr_data  input  8  write value: [7:4] operator mask S4..S1, [2:0] channel, [3] ignored.
REQ-007 SHALL have port zero  input  1  high during the clk_en cycle of slot 0 (cur_ch=0, cur_op=0).
REQ-008 SHALL have port keyon_op  output  4  operator mask presented to the key-on shift register.
REQ-009 SHALL have port keyon_ch  output  3  channel presented to the key-on shift register.
REQ-010 SHALL have port up_keyon  output  1  update strobe; high for exactly one full 24-slot frame per command.
REQ-011 SHALL have port level  output  5  number of queued commands (0..DEPTH).
REQ-012 SHALL have port ovf  output  1  sticky flag: a command was dropped (FIFO full or invalid channel).

Function
REQ-013 SHALL accept wr_en on any clk edge regardless of clk_en; FSM, frame counter and pops advance only on clk_en-high cycles.
REQ-014 SHALL discard writes with wr_data[1:0]==2'b11 (channels 3, 7 invalid) without queueing, setting ovf.
REQ-015 SHALL push {wr_data[7:4], wr_data[2:0]} into a DEPTH-entry FIFO on a valid write when not full; level increments.
REQ-016 SHALL drop a valid write arriving when level==DEPTH and no pop occurs on the same edge, setting ovf; FIFO contents unchanged.
REQ-017 SHALL, on a simultaneous push and pop with a full FIFO, perform both; level unchanged, write accepted, ovf unchanged.
REQ-018 SHALL implement FSM states IDLE, WAIT_ZERO, APPLY.
REQ-019 SHALL move IDLE -> WAIT_ZERO on the first clk_en cycle with level>0.
REQ-020 SHALL move WAIT_ZERO -> APPLY on a clk_en cycle with zero=1, loading keyon_op/keyon_ch from FIFO head and clearing a 5-bit frame counter.
REQ-021 SHALL hold up_keyon=1 and keyon_op/keyon_ch stable throughout APPLY; up_keyon rises the clock after the zero-qualified cycle.
REQ-022 SHALL count clk_en cycles in APPLY 0..23; on the clk_en cycle with count==23 pop the head, drop up_keyon next clock and go to WAIT_ZERO if level after pop >0, else IDLE.
REQ-023 SHALL thus cover all 24 slots exactly once per command; back-to-back commands apply in consecutive frames when the next zero follows count 23.
REQ-024 SHALL keep keyon_op/keyon_ch at last applied value outside APPLY; up_keyon=0 outside APPLY.
REQ-025 SHALL ignore zero outside WAIT_ZERO; a zero pulse without clk_en SHALL be ignored.
REQ-026 SHALL preserve FIFO order; commands for the same channel apply in write order.
REQ-027 SHALL report level combinationally-free (registered) and consistent with push/pop on every edge.

Reset
REQ-028 SHALL, when rst=1 on a clock edge, empty the FIFO, set level=0, ovf=0, up_keyon=0, keyon_op=0, keyon_ch=0, counter=0, state IDLE.
REQ-029 SHALL abort an in-progress APPLY on reset mid-frame; the aborted command is lost.
REQ-030 SHALL ignore wr_en asserted in the same cycle as rst.
REQ-031 SHALL clear ovf only through rst.

Verification
REQ-032 Single write 0xF1, clk_en=1 continuous, zero every 24th cycle -> up_keyon high 24 clk_en cycles starting clock after next zero, keyon_op=4'hF, keyon_ch=3'd1, level 1->0 at end.
REQ-033 Five writes 0x10,0x20,0x40,0x80,0x12 in 5 consecutive clocks with DEPTH=4, FSM idle -> first four queued, fifth dropped, ovf=1, level=4; four consecutive frames apply masks 1,2,4,8 on channel 0.
REQ-034 Write 0xF3 and 0xF7 -> no queueing, level=0, ovf=1, up_keyon stays 0.
REQ-035 clk_en toggling 1-of-6, write 0x55 -> up_keyon spans exactly 24 clk_en-high cycles (144 clocks), keyon_op=4'h5, keyon_ch=3'd5.
REQ-036 rst pulse at APPLY count 10 with 2 entries queued -> next clock up_keyon=0, level=0, ovf=0, no further APPLY without new writes.
REQ-037 FIFO full, write on the edge popping at count 23 -> write accepted, level stays 4, ovf stays 0.
